bpu_resolve: RTL and testbench
==============================

# bpu_resolve

Branch-resolution and predictor-feedback stage paired with the tournament branch predictor. It carries each fetched instruction's prediction metadata (PC, hit, taken, predicted next PC, global/local votes) through a two-register IF/ID, ID/EX pipeline. In EX it compares the prediction against the actual branch outcome and then does three things:

- raises a front-end redirect on a mispredict;
- drives the predictor's BTB, PHT and chooser update ports;
- keeps saturating branch and mispredict counters.

## Interface
Parameters:
- PC_WIDTH, 32, PC/target width
- CNT_WIDTH, 32, width of performance counters

Ports (reset i_rst_n, synchronous, active-low; clock i_clk):
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_if_vld  in  1  fetch slot holds a real instruction
- i_if_pc  in  PC_WIDTH  fetch PC
- i_pred_hit / i_pred_taken / i_pred_glb_taken / i_pred_loc_taken  in  1 each  predictor outputs for i_if_pc
- i_pred_next_pc  in  PC_WIDTH  predicted next PC
- i_stall  in  1  pipeline hold; freezes both metadata registers
- i_ex_is_br  in  1  EX instruction is a conditional branch
- i_ex_is_jmp  in  1  EX instruction is JAL/JALR
- i_ex_taken  in  1  actual branch direction (ignored when i_ex_is_jmp; jumps count as taken)
- i_ex_target  in  PC_WIDTH  actual target address
- o_redirect  out  1  mispredict; front end must load o_redirect_pc
- o_redirect_pc  out  PC_WIDTH  correct next PC
- o_upd_btb_vld, o_upd_btb_pc, o_upd_btb_br_addr  out  1/PC_WIDTH/PC_WIDTH  BTB write
- o_upd_pht_vld, o_upd_eval_vld, o_upd_pht_pc, o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken  out  1/1/PC_WIDTH/1/1/1  PHT and chooser write
- o_br_cnt, o_mispred_cnt  out  CNT_WIDTH  resolved-branch and mispredict counters

## Operation
- **Metadata record:** {vld, pc, hit, taken, next_pc, glb, loc}. Stage registers are ifid and idex.
- **Advance (~i_stall & ~o_redirect):**
  - ifid <= IF inputs, with vld = i_if_vld.
  - idex <= ifid.
- **Stall (i_stall & ~o_redirect):** both registers hold.
- **Flush (o_redirect):**
  - ifid.vld <= 0 and idex.vld <= 0.
  - The IF slot captured in the same cycle is dropped, because it is wrong-path.
  - Flush has priority over stall.
- **Resolution terms:**
  - fire = idex.vld & ~i_stall & (i_ex_is_br | i_ex_is_jmp).
  - act_taken = i_ex_is_jmp | i_ex_taken.
  - act_pc = act_taken ? i_ex_target : idex.pc + 4, modulo 2^PC_WIDTH.
- **Redirect:**
  - o_redirect = fire & (act_pc != idex.next_pc).
  - o_redirect_pc = act_pc.
  - A non-branch instruction is never checked. The predictor only predicts taken on a BTB hit, so a non-branch cannot be taken-predicted after a BTB entry is correct.
- **BTB update:**
  - o_upd_btb_vld = fire & act_taken & (idex.next_pc != i_ex_target).
  - o_upd_btb_pc = idex.pc.
  - o_upd_btb_br_addr = i_ex_target.
- **PHT update:** o_upd_pht_vld = fire & i_ex_is_br (conditional branches only).
- **Chooser update:** o_upd_eval_vld = fire & i_ex_is_br & idex.hit.
- **PHT/chooser payload:**
  - o_upd_pht_pc = idex.pc.
  - o_upd_pht_taken = i_ex_taken.
  - pred_glb/pred_loc = idex.glb/idex.loc.
- **Counters:**
  - o_br_cnt increments when fire is high.
  - o_mispred_cnt increments when o_redirect is high.
  - Both saturate at all-ones.
- **Output gating:** all update outputs are 0 whenever fire is 0. Payload outputs may carry idex values.

## Timing
- IF to resolution latency is 2 cycles without stalls: a prediction sampled in cycle N is resolved combinationally in cycle N+2.
- Redirect and update outputs are combinational from idex and the EX inputs. The predictor and front end consume them at the next posedge.
- The redirect cycle's posedge flushes; the first correct-path fetch enters ifid one cycle later.
- Stall suppresses fire, so an instruction held in EX across several stall cycles updates exactly once.
- **Reset:**
  - ifid/idex vld = 0 and counters = 0.
  - All 1-bit outputs = 0.
  - o_redirect_pc = idex.pc + 4 from zeroed registers, i.e. 4.
  - Reset mid-operation discards in-flight metadata with no update.
- i_stall together with a pending mispredict: the redirect is withheld until the stall drops.

## Structure
- The shared package holds the metadata struct typedef (bp_meta_s) and the PC increment constant (4).
- One natural sub-module: sat_counter (parameterised width, en, synchronous clear), instantiated twice for the counters.

## Test plan
- **Correct taken hit:**
  - Stimulus: pc 0x100, hit=1, taken=1, next 0x200; two cycles later is_br=1, taken=1, target 0x200.
  - Required: o_redirect=0; o_upd_pht_vld=1; o_upd_eval_vld=1; o_upd_btb_vld=0; o_br_cnt=1.
- **BTB miss, jump:**
  - Stimulus: pc 0x40, hit=0, next 0x44; EX is_jmp=1, target 0x80.
  - Required: o_redirect=1 with pc 0x80; o_upd_btb_vld=1 (0x40 -> 0x80); o_upd_pht_vld=0; ifid/idex invalid the next cycle.
- **Predicted taken, actually not taken:**
  - Stimulus: pc 0x10, next 0x300; EX is_br=1, taken=0.
  - Required: o_redirect_pc=0x14; o_upd_pht_taken=0; o_mispred_cnt=1.
- **Stall:**
  - Stimulus: hold i_stall for 3 cycles with a branch in idex.
  - Required: no update while stalled; exactly one o_upd_pht_vld pulse after release.
- **Wrong-path squash:**
  - Stimulus: mispredict in cycle N with valid entries in ifid and at IF.
  - Required: neither reaches EX; no updates in N+1 and N+2.
- **Counter saturation and reset:**
  - Stimulus: CNT_WIDTH=2 with 5 branches; then assert i_rst_n=0 mid-stream.
  - Required: o_br_cnt sticks at 3; after reset, counters are 0 and all 1-bit outputs are 0.

Source files
------------

// File: rtl/bpu_resolve_pkg.sv
// Shared types and constants for the branch-resolution / predictor-feedback stage.
// bp_meta_s is the per-instruction prediction record carried from IF to EX.
// PC fields are stored at PC_MAX_W and zero-extended from the top's PC_WIDTH.
// The upper bits stay constant zero, so PC_WIDTH must not exceed PC_MAX_W.
package bpu_resolve_pkg;

   localparam int unsigned PC_MAX_W = 64;
   localparam int unsigned PC_INC   = 4;

   typedef struct packed {
      logic                vld;
      logic [PC_MAX_W-1:0] pc;
      logic                hit;
      logic                taken;
      logic [PC_MAX_W-1:0] next_pc;
      logic                glb;
      logic                loc;
   } bp_meta_s;

endpackage

// File: rtl/bpu_resolve_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_clr           synchronous clear (wins over i_en)
//   i_en            count enable
//   o_cnt           current count
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: clear, saturating increment, or hold
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Count register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/bpu_resolve.sv
// bpu_resolve: carries prediction metadata through IF/ID and ID/EX, then
// resolves it in EX against the actual branch outcome. Produces a front-end
// redirect on mispredict, BTB/PHT/chooser update strobes, and saturating
// resolved-branch / mispredict counters.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_if_* / i_pred_*     fetch slot and predictor outputs for that slot
//   i_stall               holds both metadata registers, suppresses resolution
//   i_ex_*                EX instruction class, actual direction and target
//   o_redirect(_pc)       mispredict strobe and correct next PC (combinational)
//   o_upd_btb_*           BTB write (combinational)
//   o_upd_pht_* / o_upd_eval_vld  PHT and chooser write (combinational)
//   o_br_cnt, o_mispred_cnt       performance counters
module bpu_resolve
   import bpu_resolve_pkg::*;
#(
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_if_vld,
   input  logic [PC_WIDTH-1:0]  i_if_pc,
   input  logic                 i_pred_hit,
   input  logic                 i_pred_taken,
   input  logic                 i_pred_glb_taken,
   input  logic                 i_pred_loc_taken,
   input  logic [PC_WIDTH-1:0]  i_pred_next_pc,
   input  logic                 i_stall,
   input  logic                 i_ex_is_br,
   input  logic                 i_ex_is_jmp,
   input  logic                 i_ex_taken,
   input  logic [PC_WIDTH-1:0]  i_ex_target,
   output logic                 o_redirect,
   output logic [PC_WIDTH-1:0]  o_redirect_pc,
   output logic                 o_upd_btb_vld,
   output logic [PC_WIDTH-1:0]  o_upd_btb_pc,
   output logic [PC_WIDTH-1:0]  o_upd_btb_br_addr,
   output logic                 o_upd_pht_vld,
   output logic                 o_upd_eval_vld,
   output logic [PC_WIDTH-1:0]  o_upd_pht_pc,
   output logic                 o_upd_pht_taken,
   output logic                 o_upd_pht_pred_glb_taken,
   output logic                 o_upd_pht_pred_loc_taken,
   output logic [CNT_WIDTH-1:0] o_br_cnt,
   output logic [CNT_WIDTH-1:0] o_mispred_cnt
);

   // Keeps the sequential PC inside the PC_WIDTH address space
   localparam logic [PC_MAX_W-1:0] PC_MASK =
      (PC_WIDTH >= PC_MAX_W) ? {PC_MAX_W{1'b1}}
                             : ((PC_MAX_W'(1) << PC_WIDTH) - PC_MAX_W'(1));

   bp_meta_s ifid_q, ifid_d;
   bp_meta_s idex_q, idex_d;

   logic                fire;
   logic                act_taken;
   logic                redirect;
   logic                btb_upd;
   logic                pht_upd;
   logic                eval_upd;
   logic [PC_MAX_W-1:0] ex_target;
   logic [PC_MAX_W-1:0] seq_pc;
   logic [PC_MAX_W-1:0] act_pc;

   // Resolution of the EX-stage instruction against its prediction.
   // Reset gates fire so nothing in flight can update during reset.
   always_comb begin
      ex_target = PC_MAX_W'(i_ex_target);
      seq_pc    = (idex_q.pc + PC_MAX_W'(PC_INC)) & PC_MASK;
      act_taken = i_ex_is_jmp | i_ex_taken;
      act_pc    = act_taken ? ex_target : seq_pc;
      fire      = i_rst_n & idex_q.vld & ~i_stall & (i_ex_is_br | i_ex_is_jmp);
      redirect  = fire & (act_pc != idex_q.next_pc);
      btb_upd   = fire & act_taken & (idex_q.next_pc != ex_target);
      pht_upd   = fire & i_ex_is_br;
      eval_upd  = pht_upd & idex_q.hit;
   end

   // Pipeline advance / hold / flush; flush drops the IF slot of the same cycle
   always_comb begin
      ifid_d = ifid_q;
      idex_d = idex_q;
      if (redirect) begin
         ifid_d.vld = 1'b0;
         idex_d.vld = 1'b0;
      end else if (!i_stall) begin
         ifid_d.vld     = i_if_vld;
         ifid_d.pc      = PC_MAX_W'(i_if_pc);
         ifid_d.hit     = i_pred_hit;
         ifid_d.taken   = i_pred_taken;
         ifid_d.next_pc = PC_MAX_W'(i_pred_next_pc);
         ifid_d.glb     = i_pred_glb_taken;
         ifid_d.loc     = i_pred_loc_taken;
         idex_d         = ifid_q;
      end
   end

   // Metadata stage registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ifid_q <= '0;
         idex_q <= '0;
      end else begin
         ifid_q <= ifid_d;
         idex_q <= idex_d;
      end
   end

   assign o_redirect               = redirect;
   assign o_redirect_pc            = PC_WIDTH'(act_pc);
   assign o_upd_btb_vld            = btb_upd;
   assign o_upd_btb_pc             = PC_WIDTH'(idex_q.pc);
   assign o_upd_btb_br_addr        = i_ex_target;
   assign o_upd_pht_vld            = pht_upd;
   assign o_upd_eval_vld           = eval_upd;
   assign o_upd_pht_pc             = PC_WIDTH'(idex_q.pc);
   // 1-bit payloads are held low outside a resolution so they read 0 in reset
   assign o_upd_pht_taken          = fire & i_ex_taken;
   assign o_upd_pht_pred_glb_taken = fire & idex_q.glb;
   assign o_upd_pht_pred_loc_taken = fire & idex_q.loc;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_br_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (1'b0),
      .i_en    (fire),
      .o_cnt   (o_br_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_mispred_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (1'b0),
      .i_en    (redirect),
      .o_cnt   (o_mispred_cnt)
   );

endmodule

// File: tb/tb_bpu_resolve.sv
// Testbench for bpu_resolve: directed scenarios plus a randomized run checked
// against a reference model that tracks in-flight instructions as a queue.
module tb_bpu_resolve;

   localparam int unsigned PW   = 32;
   localparam int unsigned CW   = 2;
   localparam int          CMAX = 3;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_if_vld;
   logic [PW-1:0] i_if_pc;
   logic          i_pred_hit, i_pred_taken, i_pred_glb_taken, i_pred_loc_taken;
   logic [PW-1:0] i_pred_next_pc;
   logic          i_stall;
   logic          i_ex_is_br, i_ex_is_jmp, i_ex_taken;
   logic [PW-1:0] i_ex_target;
   logic          o_redirect;
   logic [PW-1:0] o_redirect_pc;
   logic          o_upd_btb_vld;
   logic [PW-1:0] o_upd_btb_pc, o_upd_btb_br_addr;
   logic          o_upd_pht_vld, o_upd_eval_vld;
   logic [PW-1:0] o_upd_pht_pc;
   logic          o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken;
   logic [CW-1:0] o_br_cnt, o_mispred_cnt;

   bpu_resolve #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_if_vld(i_if_vld), .i_if_pc(i_if_pc),
      .i_pred_hit(i_pred_hit), .i_pred_taken(i_pred_taken),
      .i_pred_glb_taken(i_pred_glb_taken), .i_pred_loc_taken(i_pred_loc_taken),
      .i_pred_next_pc(i_pred_next_pc), .i_stall(i_stall),
      .i_ex_is_br(i_ex_is_br), .i_ex_is_jmp(i_ex_is_jmp), .i_ex_taken(i_ex_taken),
      .i_ex_target(i_ex_target),
      .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
      .o_upd_btb_vld(o_upd_btb_vld), .o_upd_btb_pc(o_upd_btb_pc),
      .o_upd_btb_br_addr(o_upd_btb_br_addr),
      .o_upd_pht_vld(o_upd_pht_vld), .o_upd_eval_vld(o_upd_eval_vld),
      .o_upd_pht_pc(o_upd_pht_pc), .o_upd_pht_taken(o_upd_pht_taken),
      .o_upd_pht_pred_glb_taken(o_upd_pht_pred_glb_taken),
      .o_upd_pht_pred_loc_taken(o_upd_pht_pred_loc_taken),
      .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic          vld;
      logic [PW-1:0] pc;
      logic          hit;
      logic          taken;
      logic [PW-1:0] nxt;
      logic          glb;
      logic          loc;
   } rec_t;

   // Reference model: instructions in flight, oldest first; EX holds the
   // oldest once two fetch slots have been accepted since the last flush.
   rec_t flight[$];
   int   m_br, m_mis;
   int   checks, failures;

   logic          x_fire, x_redir, x_btb, x_pht, x_eval, x_taken;
   logic [PW-1:0] x_rpc, x_pc;
   logic          x_glb, x_loc;

   function automatic rec_t ex_slot();
      rec_t r;
      r = '{vld: 1'b0, pc: '0, hit: 1'b0, taken: 1'b0, nxt: '0, glb: 1'b0, loc: 1'b0};
      if (flight.size() == 2) r = flight[0];
      return r;
   endfunction

   task automatic expect_now();
      rec_t e;
      logic at;
      e       = ex_slot();
      at      = i_ex_is_jmp | i_ex_taken;
      x_rpc   = at ? i_ex_target : e.pc + 32'd4;
      x_fire  = i_rst_n && e.vld && !i_stall && (i_ex_is_br || i_ex_is_jmp);
      x_redir = x_fire && (x_rpc != e.nxt);
      x_btb   = x_fire && at && (e.nxt != i_ex_target);
      x_pht   = x_fire && i_ex_is_br;
      x_eval  = x_pht && e.hit;
      x_pc    = e.pc;
      x_taken = i_ex_taken;
      x_glb   = e.glb;
      x_loc   = e.loc;
   endtask

   // One clock edge: advance the model with the inputs present at the edge
   task automatic tick();
      rec_t r;
      expect_now();
      @(posedge i_clk);
      if (!i_rst_n) begin
         flight.delete();
         m_br  = 0;
         m_mis = 0;
      end else begin
         if (x_fire && m_br < CMAX) m_br++;
         if (x_redir && m_mis < CMAX) m_mis++;
         if (x_redir) begin
            flight.delete();
         end else if (!i_stall) begin
            r = '{vld: i_if_vld, pc: i_if_pc, hit: i_pred_hit, taken: i_pred_taken,
                  nxt: i_pred_next_pc, glb: i_pred_glb_taken, loc: i_pred_loc_taken};
            flight.push_back(r);
            if (flight.size() > 2) void'(flight.pop_front());
         end
      end
      #1;
   endtask

   task automatic set_if(input logic v, input logic [PW-1:0] pc, input logic h, input logic t,
                         input logic [PW-1:0] n, input logic g, input logic l);
      i_if_vld = v; i_if_pc = pc; i_pred_hit = h; i_pred_taken = t;
      i_pred_next_pc = n; i_pred_glb_taken = g; i_pred_loc_taken = l;
   endtask

   task automatic set_ex(input logic br, input logic jmp, input logic t, input logic [PW-1:0] tgt);
      i_ex_is_br = br; i_ex_is_jmp = jmp; i_ex_taken = t; i_ex_target = tgt;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0; i_stall = 1'b0;
      set_if(0, '0, 0, 0, '0, 0, 0);
      set_ex(0, 0, 0, '0);
      tick();
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_stall = 1'b0;
      set_if(1, 32'h123, 1, 1, 32'h456, 1, 1);
      set_ex(1, 0, 0, 32'h700);
      tick();
      tick();
      @(negedge i_clk);
      checks++; if (o_redirect !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%0b exp=0", o_redirect); end
      checks++; if ({o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld} !== 3'b000) begin failures++; $display("FAIL rst_upd_vld got=%b exp=000", {o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld}); end
      checks++; if ({o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken} !== 3'b000) begin failures++; $display("FAIL rst_payload_bits got=%b exp=000", {o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken}); end
      checks++; if (o_redirect_pc !== 32'h4) begin failures++; $display("FAIL rst_redirect_pc got=%h exp=4", o_redirect_pc); end
      checks++; if (o_br_cnt !== '0 || o_mispred_cnt !== '0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", o_br_cnt, o_mispred_cnt); end
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_taken_hit();
      do_reset();
      set_if(1, 32'h100, 1, 1, 32'h200, 1, 0);
      tick();
      set_if(0, '0, 0, 0, '0, 0, 0);
      tick();
      set_ex(1, 0, 1, 32'h200);
      @(negedge i_clk);
      checks++; if (o_redirect !== 1'b0) begin failures++; $display("FAIL hit_redirect got=%0b exp=0", o_redirect); end
      checks++; if (o_upd_pht_vld !== 1'b1) begin failures++; $display("FAIL hit_pht_vld got=%0b exp=1", o_upd_pht_vld); end
      checks++; if (o_upd_eval_vld !== 1'b1) begin failures++; $display("FAIL hit_eval_vld got=%0b exp=1", o_upd_eval_vld); end
      checks++; if (o_upd_btb_vld !== 1'b0) begin failures++; $display("FAIL hit_btb_vld got=%0b exp=0", o_upd_btb_vld); end
      checks++; if (o_upd_pht_pc !== 32'h100 || o_upd_pht_pred_glb_taken !== 1'b1 || o_upd_pht_pred_loc_taken !== 1'b0)
         begin failures++; $display("FAIL hit_payload got=%h/%0b/%0b exp=100/1/0", o_upd_pht_pc, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken); end
      tick();
      set_ex(0, 0, 0, '0);
      @(negedge i_clk);
      checks++; if (o_br_cnt !== 2'd1 || o_mispred_cnt !== 2'd0) begin failures++; $display("FAIL hit_counters got=%0d/%0d exp=1/0", o_br_cnt, o_mispred_cnt); end
      tick();
   endtask

   task automatic test_jump_miss_squash();
      do_reset();
      set_if(1, 32'h40, 0, 0, 32'h44, 0, 0);
      tick();
      set_if(1, 32'h44, 0, 0, 32'h48, 0, 0);
      tick();
      set_if(1, 32'h48, 0, 0, 32'h4c, 0, 0);
      set_ex(0, 1, 0, 32'h80);
      @(negedge i_clk);
      checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h80) begin failures++; $display("FAIL jmp_redirect got=%0b/%h exp=1/80", o_redirect, o_redirect_pc); end
      checks++; if (o_upd_btb_vld !== 1'b1 || o_upd_btb_pc !== 32'h40 || o_upd_btb_br_addr !== 32'h80)
         begin failures++; $display("FAIL jmp_btb got=%0b/%h/%h exp=1/40/80", o_upd_btb_vld, o_upd_btb_pc, o_upd_btb_br_addr); end
      checks++; if (o_upd_pht_vld !== 1'b0 || o_upd_eval_vld !== 1'b0) begin failures++; $display("FAIL jmp_pht got=%0b/%0b exp=0/0", o_upd_pht_vld, o_upd_eval_vld); end
      tick();
      // Correct-path fetch at 0x80; EX still presents a branch that must not fire
      set_if(1, 32'h80, 0, 0, 32'h84, 0, 0);
      set_ex(1, 0, 1, 32'h500);
      for (int k = 1; k <= 2; k++) begin
         @(negedge i_clk);
         checks++; if ({o_redirect, o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld} !== 4'b0000)
            begin failures++; $display("FAIL squash_n%0d got=%b exp=0000", k, {o_redirect, o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld}); end
         tick();
         set_if(0, '0, 0, 0, '0, 0, 0);
      end
      set_ex(1, 0, 0, 32'h500);
      @(negedge i_clk);
      checks++; if (o_upd_pht_vld !== 1'b1 || o_redirect !== 1'b0 || o_upd_pht_pc !== 32'h80)
         begin failures++; $display("FAIL jmp_first_correct got=%0b/%0b/%h exp=1/0/80", o_upd_pht_vld, o_redirect, o_upd_pht_pc); end
      checks++; if (o_mispred_cnt !== 2'd1 || o_br_cnt !== 2'd1) begin failures++; $display("FAIL jmp_counters got=%0d/%0d exp=1/1", o_br_cnt, o_mispred_cnt); end
      tick();
   endtask

   task automatic test_not_taken();
      do_reset();
      set_if(1, 32'h10, 1, 1, 32'h300, 1, 0);
      tick();
      set_if(0, '0, 0, 0, '0, 0, 0);
      tick();
      set_ex(1, 0, 0, 32'h300);
      @(negedge i_clk);
      checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h14) begin failures++; $display("FAIL nt_redirect got=%0b/%h exp=1/14", o_redirect, o_redirect_pc); end
      checks++; if (o_upd_pht_vld !== 1'b1 || o_upd_pht_taken !== 1'b0 || o_upd_eval_vld !== 1'b1 || o_upd_btb_vld !== 1'b0)
         begin failures++; $display("FAIL nt_updates got=%b exp=1010", {o_upd_pht_vld, o_upd_pht_taken, o_upd_eval_vld, o_upd_btb_vld}); end
      tick();
      set_ex(0, 0, 0, '0);
      @(negedge i_clk);
      checks++; if (o_mispred_cnt !== 2'd1 || o_br_cnt !== 2'd1) begin failures++; $display("FAIL nt_counters got=%0d/%0d exp=1/1", o_br_cnt, o_mispred_cnt); end
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      set_if(1, 32'h500, 0, 0, 32'h504, 0, 1);
      tick();
      set_if(0, '0, 0, 0, '0, 0, 0);
      tick();
      set_ex(1, 0, 1, 32'h900);
      i_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         checks++; if ({o_redirect, o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld} !== 4'b0000)
            begin failures++; $display("FAIL stall_c%0d got=%b exp=0000", k, {o_redirect, o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld}); end
         tick();
      end
      i_stall = 1'b0;
      @(negedge i_clk);
      checks++; if (o_upd_pht_vld !== 1'b1 || o_redirect !== 1'b1 || o_redirect_pc !== 32'h900 || o_upd_btb_vld !== 1'b1 || o_upd_pht_pred_loc_taken !== 1'b1)
         begin failures++; $display("FAIL stall_release got=%b/%h exp=1111/900", {o_upd_pht_vld, o_redirect, o_upd_btb_vld, o_upd_pht_pred_loc_taken}, o_redirect_pc); end
      tick();
      @(negedge i_clk);
      checks++; if (o_upd_pht_vld !== 1'b0 || o_redirect !== 1'b0) begin failures++; $display("FAIL stall_once got=%0b/%0b exp=0/0", o_upd_pht_vld, o_redirect); end
      checks++; if (o_br_cnt !== 2'd1 || o_mispred_cnt !== 2'd1) begin failures++; $display("FAIL stall_counters got=%0d/%0d exp=1/1", o_br_cnt, o_mispred_cnt); end
      tick();
      set_ex(0, 0, 0, '0);
   endtask

   task automatic test_saturation_reset();
      int exp_cnt;
      do_reset();
      set_ex(1, 0, 0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         if (i < 5) set_if(1, 32'h1000 + 32'(8 * i), 0, 0, 32'h1004 + 32'(8 * i), 0, 0);
         else       set_if(0, '0, 0, 0, '0, 0, 0);
         @(negedge i_clk);
         exp_cnt = (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2);
         checks++; if (o_br_cnt !== CW'(exp_cnt) || o_mispred_cnt !== '0)
            begin failures++; $display("FAIL sat_cnt_c%0d got=%0d/%0d exp=%0d/0", i, o_br_cnt, o_mispred_cnt, exp_cnt); end
         tick();
      end
      set_if(1, 32'h2000, 1, 1, 32'h3000, 1, 1);
      tick();
      set_if(0, '0, 0, 0, '0, 0, 0);
      tick();
      i_rst_n = 1'b0;
      @(negedge i_clk);
      checks++; if ({o_redirect, o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld, o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken} !== 7'b0)
         begin failures++; $display("FAIL midrst_outputs got=%b exp=0000000", {o_redirect, o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld, o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken}); end
      tick();
      i_rst_n = 1'b1;
      @(negedge i_clk);
      checks++; if (o_br_cnt !== '0 || o_mispred_cnt !== '0) begin failures++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", o_br_cnt, o_mispred_cnt); end
      checks++; if ({o_redirect, o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld} !== 4'b0 || o_redirect_pc !== 32'h4)
         begin failures++; $display("FAIL midrst_discard got=%b/%h exp=0000/4", {o_redirect, o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld}, o_redirect_pc); end
      tick();
      set_ex(0, 0, 0, '0);
   endtask

   task automatic test_random();
      rec_t          e;
      logic [PW-1:0] pc;
      int            kind;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         i_rst_n = ($urandom_range(99) != 0);
         i_stall = ($urandom_range(4) == 0);
         pc = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : (32'($urandom_range(1023)) << 2);
         set_if(1'($urandom_range(3) != 0), pc, 1'($urandom_range(1)), 1'b0, pc + 32'd4,
                1'($urandom_range(1)), 1'($urandom_range(1)));
         if (i_pred_hit && ($urandom_range(1) == 1)) begin
            i_pred_taken   = 1'b1;
            i_pred_next_pc = 32'($urandom_range(1023)) << 2;
         end
         e    = ex_slot();
         kind = $urandom_range(3);
         set_ex(kind == 1 || kind == 3, kind == 2, 1'($urandom_range(1)),
                ($urandom_range(1) == 1) ? e.nxt : (32'($urandom_range(1023)) << 2));
         @(negedge i_clk);
         expect_now();
         checks++; if (o_redirect !== x_redir) begin failures++; $display("FAIL rnd_redirect cyc=%0d got=%0b exp=%0b", cyc, o_redirect, x_redir); end
         checks++; if (o_upd_btb_vld !== x_btb) begin failures++; $display("FAIL rnd_btb_vld cyc=%0d got=%0b exp=%0b", cyc, o_upd_btb_vld, x_btb); end
         checks++; if (o_upd_pht_vld !== x_pht) begin failures++; $display("FAIL rnd_pht_vld cyc=%0d got=%0b exp=%0b", cyc, o_upd_pht_vld, x_pht); end
         checks++; if (o_upd_eval_vld !== x_eval) begin failures++; $display("FAIL rnd_eval_vld cyc=%0d got=%0b exp=%0b", cyc, o_upd_eval_vld, x_eval); end
         checks++; if (o_br_cnt !== CW'(m_br) || o_mispred_cnt !== CW'(m_mis))
            begin failures++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, o_br_cnt, o_mispred_cnt, m_br, m_mis); end
         if (x_fire) begin
            checks++; if (o_redirect_pc !== x_rpc) begin failures++; $display("FAIL rnd_redirect_pc cyc=%0d got=%h exp=%h", cyc, o_redirect_pc, x_rpc); end
         end
         if (x_btb) begin
            checks++; if (o_upd_btb_pc !== x_pc || o_upd_btb_br_addr !== i_ex_target)
               begin failures++; $display("FAIL rnd_btb_payload cyc=%0d got=%h/%h exp=%h/%h", cyc, o_upd_btb_pc, o_upd_btb_br_addr, x_pc, i_ex_target); end
         end
         if (x_pht) begin
            checks++; if (o_upd_pht_pc !== x_pc || {o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken} !== {x_taken, x_glb, x_loc})
               begin failures++; $display("FAIL rnd_pht_payload cyc=%0d got=%h/%b exp=%h/%b", cyc, o_upd_pht_pc,
                     {o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken}, x_pc, {x_taken, x_glb, x_loc}); end
         end
         tick();
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_br     = 0;
      m_mis    = 0;
      i_rst_n  = 1'b0;
      i_stall  = 1'b0;
      set_if(0, '0, 0, 0, '0, 0, 0);
      set_ex(0, 0, 0, '0);
      test_reset();
      test_taken_hit();
      test_jump_miss_squash();
      test_not_taken();
      test_stall();
      test_saturation_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
